// File: rtl/ram_1r1w_bypass_init.sv
// rtl/ram_1r1w_bypass_init.sv - parametrised 1R1W RAM with byte mask, write bypass and clear sequencer
module ram_1r1w_bypass_init #(
  parameter int                DATA_W       = 64,
  parameter int                DEPTH        = 512,
  parameter int                ADDR_W       = $clog2(DEPTH),
  parameter int                OUT_REG      = 0,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic                  re,
  output logic [DATA_W-1:0]     rd,
  output logic                  rvalid,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wr,
  input  logic [DATA_W/8-1:0]   wmask,
  input  logic                  we,
  input  logic                  init_req,
  output logic                  ready
);

  localparam int                NB   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;

  // No reset on the array so it can be mapped onto an SRAM macro.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic [NB-1:0]       mem_be;

  logic [DATA_W-1:0]   rd_raw;
  logic [DATA_W-1:0]   rd_byp;
  logic                rd_hit;
  logic                rd_acc;

  logic [DATA_W-1:0]   s1_data_q;
  logic                s1_valid_q;

  // ready_q is 1 only while state_q is IDLE, so it doubles as the accept gate.
  assign rd_acc = ready_q && re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = waddr;
    mem_wd  = wr;
    mem_be  = wmask;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = CLEAR_VAL;
        mem_be = '1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (ready_q) begin
          mem_we = we;
          if (init_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
        end
      end
    end
  end

  // Same-cycle write to the read address is merged byte-wise into the read data.
  always_comb begin
    rd_raw = mem[raddr];
    rd_hit = we && (waddr == raddr);
    rd_byp = rd_raw;
    for (int b = 0; b < NB; b++) begin
      if (rd_hit && wmask[b]) begin
        rd_byp[8*b +: 8] = wr[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rd_byp;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_data_q;
      logic              s2_valid_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign rd     = s2_data_q;
      assign rvalid = s2_valid_q;
    end else begin : g_no_out_reg
      assign rd     = s1_data_q;
      assign rvalid = s1_valid_q;
    end
  endgenerate

  assign ready = ready_q;

endmodule
